// File: rtl/led_pattern_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Purpose  : Shared mode encoding and pattern constants for the LED sequencer.
// Revision : 1.0  initial release
// ============================================================================
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_R  = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam logic [7:0] LED_INIT   = 8'hFE;
    localparam logic [7:0] LED_OFF    = 8'hFF;
    localparam logic [2:0] BOUNCE_MAX = 3'd7;
    localparam logic [3:0] FILL_MAX   = 4'd8;
    localparam logic       DIR_UP     = 1'b0;
    localparam logic       DIR_DOWN   = 1'b1;

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_tick_gen
// Purpose  : Step-rate prescaler; emits a one-cycle tick every BASE_DIV<<spd clocks.
// Revision : 1.0  initial release
// ============================================================================
module led_tick_gen #(
    parameter int BASE_DIV = 6000000,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       pause,
    input  logic [1:0] spd,
    output logic       tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] w_limit;

    // A >= compare lets a freshly lowered spd fire at once instead of wrapping.
    always_comb begin
        w_limit = (CNT_W'(BASE_DIV) << spd) - CNT_W'(1);
        cnt_d   = cnt_q;
        tick    = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (!pause) begin
            if (cnt_q >= w_limit) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl
// Purpose  : 8-LED sequencer with four patterns, programmable rate and pause.
// Revision : 1.0  initial release
// ============================================================================
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int BASE_DIV = 6000000,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_next,
    input  logic       pause,
    input  logic [1:0] spd,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       step
);

    mode_e       mode_q, mode_d;
    mode_e       w_mode_inc;
    logic [7:0]  led_q, led_d;
    logic [2:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [3:0]  fill_q, fill_d;
    logic        step_q, step_d;
    logic        w_tick;

    led_tick_gen #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (mode_next),
        .pause (pause),
        .spd   (spd),
        .tick  (w_tick)
    );

    // Mode entry outranks a coincident tick: reload, no step pulse.
    always_comb begin
        mode_d     = mode_q;
        led_d      = led_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        fill_d     = fill_q;
        step_d     = 1'b0;
        w_mode_inc = mode_e'(2'(mode_q + 2'd1));
        if (mode_next) begin
            mode_d = w_mode_inc;
            pos_d  = 3'd0;
            dir_d  = DIR_UP;
            fill_d = 4'd0;
            led_d  = (w_mode_inc == MODE_FILL) ? LED_OFF : LED_INIT;
        end else if (w_tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_ROT_R: led_d = {led_q[0], led_q[7:1]};
                MODE_ROT_L: led_d = {led_q[6:0], led_q[7]};
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        pos_d = pos_q + 3'd1;
                        if (pos_d == BOUNCE_MAX) dir_d = DIR_DOWN;
                    end else begin
                        pos_d = pos_q - 3'd1;
                        if (pos_d == 3'd0) dir_d = DIR_UP;
                    end
                    led_d = ~(8'd1 << pos_d);
                end
                MODE_FILL: begin
                    fill_d = (fill_q == FILL_MAX) ? 4'd0 : fill_q + 4'd1;
                    led_d  = ~8'((9'd1 << fill_d) - 9'd1);
                end
                default: led_d = LED_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_ROT_R;
            led_q  <= LED_INIT;
            pos_q  <= 3'd0;
            dir_q  <= DIR_UP;
            fill_q <= 4'd0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            fill_q <= fill_d;
            step_q <= step_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule : led_pattern_ctrl
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_ctrl
// Purpose  : Directed plus randomized self-checking bench for led_pattern_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_ctrl;

    localparam int BASE_DIV = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       mode_next = 1'b0;
    logic       pause     = 1'b0;
    logic [1:0] spd       = 2'd0;
    logic [7:0] led;
    logic [1:0] mode;
    logic       step;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: mode, steps taken since mode entry, prescaler count.
    int   m_mode = 0;
    int   m_k    = 0;
    int   m_cnt  = 0;
    logic m_step = 1'b0;

    led_pattern_ctrl #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_next (mode_next),
        .pause     (pause),
        .spd       (spd),
        .led       (led),
        .mode      (mode),
        .step      (step)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_led(input int md, input int k);
        logic [15:0] dbl;
        logic [8:0]  msk;
        int          p;
        dbl = {8'hFE, 8'hFE};
        case (md)
            0: begin dbl = dbl >> (k % 8); return dbl[7:0]; end
            1: begin dbl = dbl << (k % 8); return dbl[15:8]; end
            2: begin
                p = k % 14;
                if (p > 7) p = 14 - p;
                return ~(8'd1 << p);
            end
            default: begin
                msk = (9'd1 << (k % 9)) - 9'd1;
                return ~msk[7:0];
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clk1();
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_k = 0; m_cnt = 0; m_step = 1'b0;
        end else if (mode_next) begin
            m_mode = (m_mode + 1) % 4; m_k = 0; m_cnt = 0; m_step = 1'b0;
        end else if (pause) begin
            m_step = 1'b0;
        end else if (m_cnt >= (BASE_DIV << spd) - 1) begin
            m_cnt = 0; m_k++; m_step = 1'b1;
        end else begin
            m_cnt++; m_step = 1'b0;
        end
        #1;
        check("led",  {24'd0, led},  {24'd0, exp_led(m_mode, m_k)});
        check("mode", {30'd0, mode}, 32'(m_mode));
        check("step", {31'd0, step}, {31'd0, m_step});
    endtask

    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            clk1();
            cyc++;
        end while (step !== 1'b1 && cyc < 200);
        check("step_seen", {31'd0, step}, 32'd1);
    endtask

    task automatic pulse_mode();
        mode_next = 1'b1;
        clk1();
        mode_next = 1'b0;
    endtask

    logic [7:0] rotr_tab [8]  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] rotl_tab [3]  = '{8'hFD, 8'hFB, 8'hF7};
    int         bpos_tab [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    logic [7:0] fill_tab [10] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFF, 8'hFE};

    initial begin
        int cyc;
        int total;
        logic [7:0] bled;

        clk1();
        clk1();
        rst = 1'b0;
        check("rst_led",  {24'd0, led},  32'hFE);
        check("rst_mode", {30'd0, mode}, 32'd0);
        check("rst_step", {31'd0, step}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            wait_step(cyc);
            check("rotr_interval", 32'(cyc), 32'd4);
            check("rotr_led", {24'd0, led}, {24'd0, rotr_tab[i]});
        end

        pulse_mode();
        check("rotl_mode", {30'd0, mode}, 32'd1);
        check("rotl_entry_led", {24'd0, led}, 32'hFE);
        for (int i = 0; i < 3; i++) begin
            wait_step(cyc);
            check("rotl_interval", 32'(cyc), 32'd4);
            check("rotl_led", {24'd0, led}, {24'd0, rotl_tab[i]});
        end

        pulse_mode();
        check("bounce_mode", {30'd0, mode}, 32'd2);
        for (int i = 0; i < 16; i++) begin
            wait_step(cyc);
            bled = ~(8'd1 << bpos_tab[i]);
            check("bounce_led", {24'd0, led}, {24'd0, bled});
        end

        pulse_mode();
        check("fill_mode", {30'd0, mode}, 32'd3);
        check("fill_entry_led", {24'd0, led}, 32'hFF);
        for (int i = 0; i < 10; i++) begin
            wait_step(cyc);
            check("fill_led", {24'd0, led}, {24'd0, fill_tab[i]});
        end

        spd = 2'd2;
        pulse_mode();
        check("wrap_mode", {30'd0, mode}, 32'd0);
        wait_step(cyc);
        check("spd2_first", 32'(cyc), 32'd16);
        wait_step(cyc);
        check("spd2_interval", 32'(cyc), 32'd16);

        for (int i = 0; i < 10; i++) clk1();
        spd = 2'd0;
        wait_step(cyc);
        check("spd_drop", 32'(cyc), 32'd1);
        wait_step(cyc);
        check("spd0_after_drop", 32'(cyc), 32'd4);

        clk1();
        clk1();
        pause = 1'b1;
        for (int i = 0; i < 20; i++) clk1();
        pause = 1'b0;
        wait_step(cyc);
        total = 22 + cyc;
        check("pause_delay", 32'(total), 32'd24);

        clk1();
        clk1();
        clk1();
        pulse_mode();
        check("tick_collide_step", {31'd0, step}, 32'd0);
        check("tick_collide_mode", {30'd0, mode}, 32'd1);
        check("tick_collide_led",  {24'd0, led},  32'hFE);
        wait_step(cyc);
        check("tick_collide_next", 32'(cyc), 32'd4);

        pulse_mode();
        for (int i = 0; i < 3; i++) wait_step(cyc);
        clk1();
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        check("mid_rst_led",  {24'd0, led},  32'hFE);
        check("mid_rst_mode", {30'd0, mode}, 32'd0);
        wait_step(cyc);
        check("mid_rst_first", 32'(cyc), 32'd4);

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            mode_next = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 11) == 0) pause = ~pause;
            if ($urandom_range(0, 39) == 0) spd = 2'($urandom_range(0, 3));
            clk1();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_led_pattern_ctrl
`default_nettype wire

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the 8-LED bank. It replaces the fixed single-pattern chaser with four selectable patterns (rotate right, rotate left, bounce, fill), a programmable step rate, pause, and a mode-advance input. It sits between the board clock/button front end and the LED pins. Outputs are active-low: a 0 bit is a lit LED.

## Interface
Parameters:
- `BASE_DIV`, default 6000000: clocks per step at speed 0 (0.5 s at 12 MHz). Must be ≥ 2. Benches use 4.
- `CNT_W`, default 32: prescaler counter width. Must hold `BASE_DIV<<3`.

Ports:
- `clk`, in, 1: board clock; sole clock domain.
- `rst`, in, 1: reset, synchronous, active-high; overrides all other inputs.
- `mode_next`, in, 1: single-cycle pulse (debounced upstream); advances the mode.
- `pause`, in, 1: level; while high, no steps occur.
- `spd`, in, 2: step period = `BASE_DIV << spd` clocks (spd 0 fastest, 3 slowest).
- `led`, out, 8: LED drive, active-low, registered.
- `mode`, out, 2: current mode, registered.
- `step`, out, 1: 1-cycle pulse in the cycle `led` takes a new pattern value.

## Operation
- Modes: 0 ROT_R, 1 ROT_L, 2 BOUNCE, 3 FILL. `mode_next` sets mode to mode+1, wrapping 3→0.
- Step rules (applied on tick):
  - ROT_R: `led <= {led[0], led[7:1]}`.
  - ROT_L: `led <= {led[6:0], led[7]}`.
  - BOUNCE:
    - 3-bit `pos` plus `dir` flag; `led = ~(8'b1 << pos)`.
    - With dir up, pos increments; on reaching 7, dir flips to down.
    - With dir down, pos decrements; on reaching 0, dir flips to up.
    - Sequence of pos: 0,1,…,7,6,…,0,1,… (period 14 steps, no end repeated).
  - FILL:
    - 4-bit `fill` counts 0→8, then wraps to 0; `led = ~((9'b1 << fill) - 1)`, truncated to 8 bits.
    - Sequence of led: FF, FE, FC, …, 00, FF (period 9 steps).
- Mode entry (on reset or `mode_next`):
  - Pattern state reloads: ROT_R/ROT_L `led=8'hFE`; BOUNCE pos=0, dir=up, `led=8'hFE`; FILL fill=0, `led=8'hFF`.
  - Prescaler clears to 0.
- Reset values: `led=8'hFE`, `mode=0`, `step=0`; prescaler, pos and fill are 0; dir=up.

## Timing
- Prescaler behaviour per cycle, when not paused:
  - If `cnt >= (BASE_DIV<<spd)-1`: cnt ← 0, tick asserts.
  - Otherwise: cnt ← cnt+1.
  - The `>=` compare makes a lowered `spd` take effect without overrun.
- Tick-to-output latency:
  - Tick registers into `led`/`step`; new `led` and `step=1` are visible one cycle after the tick cycle.
  - Steps are exactly `BASE_DIV<<spd` clocks apart under constant `spd`.
  - First step after reset or mode entry comes `BASE_DIV<<spd` clocks after the clearing edge.
- `pause`:
  - High: cnt holds, no tick, `led` frozen, `step=0`.
  - Low: counting resumes from the held cnt; no cycles are lost and none are double-counted.
- Simultaneous events:
  - `mode_next` and tick in the same cycle: mode change wins; no step, no `step` pulse; reload values appear next cycle.
  - `mode_next` while paused: mode still advances and reloads.
  - `rst` high: every other input is ignored; outputs hold reset values the cycle after the edge.
- `spd` change mid-period: the new limit is applied to the current cnt immediately.

## Structure
- Package `led_ctrl_pkg`:
  - Mode encoding constants `MODE_ROT_R/ROT_L/BOUNCE/FILL`.
  - `LED_INIT = 8'hFE`, `LED_OFF = 8'hFF`.
  - `BOUNCE_MAX = 7`, `FILL_MAX = 8`.
- Sub-module `led_tick_gen`:
  - Inputs: clk, rst, clr, pause, spd.
  - Output: tick.
  - Parameters: `BASE_DIV`, `CNT_W`.
  - Contains the prescaler only.
- Top level `led_pattern_ctrl` holds mode, pattern registers and next-pattern logic.

## Test plan
All scenarios use `BASE_DIV=4`.
1. Reset, spd=0, ROT_R → `step` every 4 clocks; `led` = FE, 7F, BF, DF, …, FE after 8 steps.
2. One `mode_next` pulse after reset → `mode=1`, `led=FE`; next steps give FD, FB, F7; `mode_next` at mode 3 → mode 0.
3. BOUNCE, 16 steps → pos sequence 1..7, 6..0, 1, 2 (`led` 7F at pos 7, FE at pos 0); FILL, 10 steps → FE, FC, F8, F0, E0, C0, 80, 00, FF, FE.
4. Timing:
   - spd=2 → steps 16 clocks apart.
   - Switch to spd=0 at cnt=10 → step on the next cycle, then every 4.
   - `pause` for 20 clocks mid-period → step delayed by exactly 20.
5. `mode_next` in the tick cycle → no `step` pulse, pattern reloads, next step 4 clocks later; `rst` asserted mid-BOUNCE → `led=FE`, `mode=0`, first step 4 clocks after release.
